// File: rtl/ctrl_pkg.sv
// Shared types and constants for the ctrl_seq instruction sequencer.
// Holds the FSM state encoding, the opcode constants and the decoded op classes.
package ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_DECODE  = 3'd1,
      S_EXEC    = 3'd2,
      S_EXEC2   = 3'd3,
      S_WB      = 3'd4,
      S_HALTED  = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      CLS_NOOP     = 3'd0,
      CLS_SINGLE   = 3'd1,
      CLS_EXTENDED = 3'd2,
      CLS_HALT     = 3'd3,
      CLS_ILLEGAL  = 3'd4
   } op_class_t;

   localparam int OP_NOOP   = 0;
   localparam int OP_EXT1   = 8;
   localparam int OP_EXT2   = 9;
   localparam int LUOP_EXT1 = 1;
   localparam int LUOP_EXT2 = 2;

endpackage

// File: rtl/ctrl_seq_if.sv
// Opcode handshake and logic-unit control bundle between a producer and ctrl_seq.
// instr moves on a rising edge where instr_valid && instr_ready; the producer holds instr stable while valid.
interface ctrl_seq_if #(
   parameter int OPC_W  = 4,
   parameter int LUOP_W = 3
);
   logic              instr_valid;
   logic [OPC_W-1:0]  instr;
   logic              instr_ready;
   logic              stall;
   logic [LUOP_W-1:0] luop;
   logic              lu_en;
   logic              acc_we;
   logic              illegal;
   logic              halted;

   modport master (
      output instr_valid, instr, stall,
      input  instr_ready, luop, lu_en, acc_we, illegal, halted
   );

   modport slave (
      input  instr_valid, instr, stall,
      output instr_ready, luop, lu_en, acc_we, illegal, halted
   );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: maps the full-width opcode to an op class and a logic-unit select.
module ctrl_decode
   import ctrl_pkg::*;
#(
   parameter int OPC_W  = 4,
   parameter int LUOP_W = 3
) (
   input  logic [OPC_W-1:0]  opcode,
   output logic [LUOP_W-1:0] luop,
   output op_class_t         op_class
);

   always_comb begin
      luop     = '0;
      op_class = CLS_ILLEGAL;
      // Full-width compares so wider opcodes only halt on all-ones.
      if (opcode == OPC_W'(OP_NOOP)) begin
         op_class = CLS_NOOP;
      end else if (opcode == '1) begin
         op_class = CLS_HALT;
      end else if (opcode < OPC_W'(OP_EXT1)) begin
         op_class  = CLS_SINGLE;
         luop[2:0] = opcode[2:0];
      end else if (opcode == OPC_W'(OP_EXT1)) begin
         op_class = CLS_EXTENDED;
         luop     = LUOP_W'(LUOP_EXT1);
      end else if (opcode == OPC_W'(OP_EXT2)) begin
         op_class = CLS_EXTENDED;
         luop     = LUOP_W'(LUOP_EXT2);
      end
   end

endmodule

// File: rtl/ctrl_seq.sv
// Instruction sequencer: accepts one opcode at a time, drives the logic unit
// through EXEC/EXEC2 (stallable), strobes accumulator write-back, and can halt.
module ctrl_seq
   import ctrl_pkg::*;
#(
   parameter int OPC_W  = 4,
   parameter int LUOP_W = 3
) (
   input  logic       clk,
   input  logic       rst,
   ctrl_seq_if.slave  bus,
   output state_t     state_dbg
);

   state_t            state_q, state_d;
   logic [OPC_W-1:0]  opc_q;
   logic [LUOP_W-1:0] luop_q;
   logic [LUOP_W-1:0] dec_luop;
   op_class_t         dec_class;
   logic              illegal_q;

   ctrl_decode #(.OPC_W(OPC_W), .LUOP_W(LUOP_W)) u_decode (
      .opcode   (opc_q),
      .luop     (dec_luop),
      .op_class (dec_class)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         opc_q     <= '0;
         luop_q    <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == S_IDLE && bus.instr_valid) begin
            opc_q <= bus.instr;
         end
         if (state_q == S_DECODE &&
             (dec_class == CLS_SINGLE || dec_class == CLS_EXTENDED)) begin
            luop_q <= dec_luop;
         end
         illegal_q <= (state_q == S_DECODE) && (dec_class == CLS_ILLEGAL);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (bus.instr_valid) state_d = S_DECODE;
         S_DECODE: begin
            case (dec_class)
               CLS_SINGLE, CLS_EXTENDED: state_d = S_EXEC;
               CLS_HALT:                 state_d = S_HALTED;
               default:                  state_d = S_IDLE;
            endcase
         end
         S_EXEC: begin
            if (!bus.stall) begin
               state_d = (dec_class == CLS_EXTENDED) ? S_EXEC2 : S_WB;
            end
         end
         S_EXEC2:  if (!bus.stall) state_d = S_WB;
         S_WB:     state_d = S_IDLE;
         S_HALTED: state_d = S_HALTED;
         default:  state_d = S_IDLE;
      endcase
   end

   assign bus.instr_ready = (state_q == S_IDLE);
   assign bus.luop        = luop_q;
   assign bus.lu_en       = (state_q == S_EXEC) || (state_q == S_EXEC2);
   assign bus.acc_we      = (state_q == S_WB);
   assign bus.illegal     = illegal_q;
   assign bus.halted      = (state_q == S_HALTED);
   assign state_dbg       = state_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed bench for ctrl_seq: default-width instance plus a 6/4-bit instance.
module tb_ctrl_seq;
   import ctrl_pkg::*;

   logic   clk = 1'b0;
   logic   rst;
   state_t state_a, state_b;
   int     vectors = 0;
   int     miscompares = 0;

   ctrl_seq_if #(.OPC_W(4), .LUOP_W(3)) bus_a ();
   ctrl_seq_if #(.OPC_W(6), .LUOP_W(4)) bus_b ();

   ctrl_seq #(.OPC_W(4), .LUOP_W(3)) dut_a (
      .clk(clk), .rst(rst), .bus(bus_a), .state_dbg(state_a)
   );
   ctrl_seq #(.OPC_W(6), .LUOP_W(4)) dut_b (
      .clk(clk), .rst(rst), .bus(bus_b), .state_dbg(state_b)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      bus_a.instr_valid = 1'b0; bus_a.instr = '0; bus_a.stall = 1'b0;
      bus_b.instr_valid = 1'b0; bus_b.instr = '0; bus_b.stall = 1'b0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_ready",   bus_a.instr_ready, 1);
      chk("rst_luop",    bus_a.luop, 0);
      chk("rst_lu_en",   bus_a.lu_en, 0);
      chk("rst_acc_we",  bus_a.acc_we, 0);
      chk("rst_illegal", bus_a.illegal, 0);
      chk("rst_halted",  bus_a.halted, 0);
      chk("rst_state",   state_a, S_IDLE);

      // Single-cycle op 3
      bus_a.instr = 4'd3; bus_a.instr_valid = 1'b1;
      tick(); bus_a.instr_valid = 1'b0; bus_a.instr = 4'd0;
      chk("op3_dec_ready", bus_a.instr_ready, 0);
      chk("op3_dec_lu_en", bus_a.lu_en, 0);
      tick();
      chk("op3_exec_lu_en", bus_a.lu_en, 1);
      chk("op3_exec_luop",  bus_a.luop, 3);
      chk("op3_exec_acc",   bus_a.acc_we, 0);
      tick();
      chk("op3_wb_acc",   bus_a.acc_we, 1);
      chk("op3_wb_lu_en", bus_a.lu_en, 0);
      chk("op3_wb_luop",  bus_a.luop, 3);
      tick();
      chk("op3_idle_ready", bus_a.instr_ready, 1);
      chk("op3_idle_acc",   bus_a.acc_we, 0);

      // Extended op 8, stalled in the first EXEC cycle
      bus_a.instr = 4'd8; bus_a.instr_valid = 1'b1; bus_a.stall = 1'b1;
      tick(); bus_a.instr_valid = 1'b0;
      tick();
      chk("op8_exec1_lu_en", bus_a.lu_en, 1);
      chk("op8_exec1_luop",  bus_a.luop, 1);
      chk("op8_exec1_state", state_a, S_EXEC);
      tick(); bus_a.stall = 1'b0;
      chk("op8_exec2_lu_en", bus_a.lu_en, 1);
      chk("op8_exec2_state", state_a, S_EXEC);
      chk("op8_exec2_acc",   bus_a.acc_we, 0);
      tick();
      chk("op8_ext_lu_en", bus_a.lu_en, 1);
      chk("op8_ext_state", state_a, S_EXEC2);
      chk("op8_ext_luop",  bus_a.luop, 1);
      tick();
      chk("op8_wb_acc",   bus_a.acc_we, 1);
      chk("op8_wb_lu_en", bus_a.lu_en, 0);
      chk("op8_wb_luop",  bus_a.luop, 1);
      tick();
      chk("op8_idle_acc",   bus_a.acc_we, 0);
      chk("op8_idle_ready", bus_a.instr_ready, 1);

      // Extended op 9, stalled once in EXEC2
      bus_a.instr = 4'd9; bus_a.instr_valid = 1'b1;
      tick(); bus_a.instr_valid = 1'b0;
      tick();
      chk("op9_exec_luop", bus_a.luop, 2);
      tick(); bus_a.stall = 1'b1;
      chk("op9_ext_state", state_a, S_EXEC2);
      tick(); bus_a.stall = 1'b0;
      chk("op9_stall_state", state_a, S_EXEC2);
      chk("op9_stall_lu_en", bus_a.lu_en, 1);
      tick();
      chk("op9_wb_acc", bus_a.acc_we, 1);
      tick();
      chk("op9_idle_ready", bus_a.instr_ready, 1);

      // NOOP keeps luop, then op 5
      bus_a.instr = 4'd0; bus_a.instr_valid = 1'b1;
      tick(); bus_a.instr_valid = 1'b0;
      chk("noop_dec_lu_en", bus_a.lu_en, 0);
      tick();
      chk("noop_idle_ready", bus_a.instr_ready, 1);
      chk("noop_luop",       bus_a.luop, 2);
      chk("noop_lu_en",      bus_a.lu_en, 0);
      chk("noop_acc",        bus_a.acc_we, 0);
      bus_a.instr = 4'd5; bus_a.instr_valid = 1'b1;
      tick(); bus_a.instr_valid = 1'b0;
      tick();
      chk("op5_exec_luop", bus_a.luop, 5);
      tick();
      chk("op5_wb_acc", bus_a.acc_we, 1);
      tick();
      chk("op5_idle_luop", bus_a.luop, 5);

      // Illegal opcode 0xC
      bus_a.instr = 4'hC; bus_a.instr_valid = 1'b1;
      tick(); bus_a.instr_valid = 1'b0;
      chk("ill_dec_illegal", bus_a.illegal, 0);
      tick();
      chk("ill_pulse",   bus_a.illegal, 1);
      chk("ill_ready",   bus_a.instr_ready, 1);
      chk("ill_lu_en",   bus_a.lu_en, 0);
      chk("ill_luop",    bus_a.luop, 5);
      tick();
      chk("ill_cleared", bus_a.illegal, 0);

      // Reset mid-EXEC aborts without write-back
      bus_a.instr = 4'd6; bus_a.instr_valid = 1'b1;
      tick(); bus_a.instr_valid = 1'b0;
      tick();
      chk("abort_exec_lu_en", bus_a.lu_en, 1);
      rst = 1'b1;
      tick(); rst = 1'b0;
      chk("abort_acc",   bus_a.acc_we, 0);
      chk("abort_luop",  bus_a.luop, 0);
      chk("abort_ready", bus_a.instr_ready, 1);
      tick();
      chk("abort_acc2",  bus_a.acc_we, 0);
      chk("abort_state", state_a, S_IDLE);

      // HALT, then ignore valid opcodes until reset
      bus_a.instr = 4'hF; bus_a.instr_valid = 1'b1;
      tick(); bus_a.instr = 4'd3;
      tick();
      chk("halt_halted", bus_a.halted, 1);
      chk("halt_ready",  bus_a.instr_ready, 0);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("halt_hold_ready",  bus_a.instr_ready, 0);
         chk("halt_hold_halted", bus_a.halted, 1);
      end
      chk("halt_no_lu_en", bus_a.lu_en, 0);
      rst = 1'b1; bus_a.instr_valid = 1'b0;
      tick(); rst = 1'b0;
      chk("halt_rst_halted", bus_a.halted, 0);
      chk("halt_rst_ready",  bus_a.instr_ready, 1);

      // Wide instance: OPC_W=6, LUOP_W=4
      bus_b.instr = 6'd7; bus_b.instr_valid = 1'b1;
      tick(); bus_b.instr_valid = 1'b0;
      tick();
      chk("w_op7_luop",  bus_b.luop, 4'b0111);
      chk("w_op7_lu_en", bus_b.lu_en, 1);
      tick();
      chk("w_op7_acc", bus_b.acc_we, 1);
      tick();
      bus_b.instr = 6'h0F; bus_b.instr_valid = 1'b1;
      tick(); bus_b.instr_valid = 1'b0;
      tick();
      chk("w_0f_illegal", bus_b.illegal, 1);
      chk("w_0f_halted",  bus_b.halted, 0);
      chk("w_0f_luop",    bus_b.luop, 7);
      tick();
      bus_b.instr = 6'h3F; bus_b.instr_valid = 1'b1;
      tick(); bus_b.instr_valid = 1'b0;
      tick();
      chk("w_3f_halted", bus_b.halted, 1);
      chk("w_3f_ready",  bus_b.instr_ready, 0);
      chk("w_a_idle",    bus_a.instr_ready, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
